// File: rtl/key_debounce_if.sv
// key_debounce_if: bundles the raw pushbutton inputs and the conditioned key
// outputs of key_debounce.
//   key           raw active-low pushbuttons (driven by master)
//   key_held      debounced level, active-high
//   key_press     one-cycle pulse on accepted press
//   key_release   one-cycle pulse on accepted release
//   key_press_any OR of key_press
// master: board / testbench side, slave: key_debounce side.
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                key_press_any;

    modport master (
        output key,
        input  key_held, key_press, key_release, key_press_any
    );

    modport slave (
        input  key,
        output key_held, key_press, key_release, key_press_any
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: per-key two-flop synchroniser, counter debounce and registered
// press/release pulses for active-low pushbuttons.
// Ports:
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   kb    key_debounce_if slave: key in; key_held, key_press, key_release,
//         key_press_any out
// A new level is accepted after DEBOUNCE_CYCLES consecutive samples that
// differ from the current stable level; any matching sample restarts the
// count, so shorter glitches never get through.
module key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    key_debounce_if.slave kb
);
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel states: derived from (sync2 != s), no separate state register.
    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] s_q, s_d;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                any_q, any_d;

    always_comb begin
        logic [0:0] st;
        st    = ST_STABLE;
        s_d   = s_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            st = (sync2_q[i] != s_q[i]) ? ST_COUNTING : ST_STABLE;
            case (st)
                ST_COUNTING: begin
                    if (cnt_q[i] == TERM) begin
                        // Accepted change: the count restarts for the next edge.
                        s_d[i]   = sync2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: cnt_d[i] = '0;  // match, or bounce back: restart
            endcase
        end
        // Pulses come from the stable-state transition itself so they line up
        // with key_held on the same edge.
        press_d   = s_q & ~s_d;
        release_d = ~s_q & s_d;
        held_d    = ~s_d;
        any_d     = |press_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            s_q       <= '1;
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
            held_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            sync1_q   <= kb.key;
            sync2_q   <= sync1_q;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
        end
    end

    assign kb.key_held      = held_q;
    assign kb.key_press     = press_q;
    assign kb.key_release   = release_q;
    assign kb.key_press_any = any_q;
endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;
    localparam int NK = 4;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_debounce_if #(.NUM_KEYS(NK)) kif ();

    key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kb    (kif.slave)
    );

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    // Reference model: the level accepted at an edge is decided purely from
    // the last D raw samples that have reached the debouncer (two edges old).
    logic [NK-1:0] raw_q[$];
    logic [NK-1:0] ms;
    logic [NK-1:0] e_held, e_press, e_rel;
    logic          e_any;

    // Event bookkeeping for directed latency checks.
    int            press_cyc[NK], rel_cyc[NK], press_cnt[NK], rel_cnt[NK];
    logic [NK-1:0] held_ever;
    logic [NK-1:0] last_press_vec;
    logic          last_any;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        raw_q = {};
        for (int j = 0; j < D + 2; j++) raw_q.push_back('1);
        ms = '1;
        e_held = '0; e_press = '0; e_rel = '0; e_any = 1'b0;
    endtask

    task automatic model_edge(input logic [NK-1:0] k);
        logic [NK-1:0] s_new;
        logic          all_diff;
        raw_q.push_back(k);
        void'(raw_q.pop_front());
        s_new = ms;
        for (int i = 0; i < NK; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
                if (raw_q[j][i] == ms[i]) all_diff = 1'b0;
            if (all_diff) s_new[i] = ~ms[i];
        end
        e_press = ms & ~s_new;
        e_rel   = ~ms & s_new;
        e_held  = ~s_new;
        e_any   = |e_press;
        ms      = s_new;
    endtask

    task automatic tick(input logic [NK-1:0] k, input logic r);
        @(negedge clk);
        kif.key = k;
        rst_n   = r;
        @(posedge clk);
        cyc++;
        if (!r) model_reset();
        else    model_edge(k);
        #1;
        chk("key_held",      32'(kif.key_held),      32'(e_held));
        chk("key_press",     32'(kif.key_press),     32'(e_press));
        chk("key_release",   32'(kif.key_release),   32'(e_rel));
        chk("key_press_any", 32'(kif.key_press_any), 32'(e_any));
        for (int i = 0; i < NK; i++) begin
            if (kif.key_press[i])   begin press_cyc[i] = cyc; press_cnt[i]++; end
            if (kif.key_release[i]) begin rel_cyc[i]   = cyc; rel_cnt[i]++;   end
        end
        held_ever = held_ever | kif.key_held;
        if (kif.key_press != '0) begin
            last_press_vec = kif.key_press;
            last_any       = kif.key_press_any;
        end
    endtask

    task automatic run(input logic [NK-1:0] k, input int n);
        for (int j = 0; j < n; j++) tick(k, 1'b1);
    endtask

    initial begin
        int t0, pc0, pc1, rc2;
        logic [NK-1:0] k;
        int hold;

        for (int i = 0; i < NK; i++) begin
            press_cyc[i] = -1; rel_cyc[i] = -1; press_cnt[i] = 0; rel_cnt[i] = 0;
        end
        held_ever = '0; last_press_vec = '0; last_any = 1'b0;
        rst_n   = 1'b0;
        kif.key = 4'h0;
        model_reset();

        // Reset with all keys down: outputs stay 0, then every key is pressed.
        tick(4'h0, 1'b0);
        tick(4'h0, 1'b0);
        t0 = cyc + 1;
        run(4'h0, 10);
        for (int i = 0; i < NK; i++) begin
            chk("rst_press_cyc", 32'(press_cyc[i]), 32'(t0 + 5));
            chk("rst_press_cnt", 32'(press_cnt[i]), 32'd1);
        end
        chk("rst_press_vec", 32'(last_press_vec), 32'hF);
        chk("rst_press_any", 32'(last_any), 32'd1);
        run(4'hF, 12);

        // Clean press and release on key 0.
        pc0 = press_cnt[0];
        t0  = cyc + 1;
        run(4'hE, 20);
        chk("clean_press_cyc", 32'(press_cyc[0]), 32'(t0 + 5));
        chk("clean_press_cnt", 32'(press_cnt[0] - pc0), 32'd1);
        t0 = cyc + 1;
        run(4'hF, 12);
        chk("clean_rel_cyc", 32'(rel_cyc[0]), 32'(t0 + 5));

        // Bounce on key 1, then steady low.
        pc1 = press_cnt[1];
        run(4'hD, 3); run(4'hF, 1); run(4'hD, 2); run(4'hF, 1);
        chk("bounce_no_early", 32'(press_cnt[1] - pc1), 32'd0);
        t0 = cyc + 1;
        run(4'hD, 12);
        chk("bounce_press_cnt", 32'(press_cnt[1] - pc1), 32'd1);
        chk("bounce_press_cyc", 32'(press_cyc[1]), 32'(t0 + 5));
        run(4'hF, 12);

        // Short glitch on key 2 is never accepted.
        pc1 = press_cnt[2]; rc2 = rel_cnt[2]; held_ever = '0;
        run(4'hB, 3);
        run(4'hF, 10);
        chk("glitch_press", 32'(press_cnt[2] - pc1), 32'd0);
        chk("glitch_rel",   32'(rel_cnt[2] - rc2),   32'd0);
        chk("glitch_held",  32'(held_ever[2]),       32'd0);

        // Keys 3 and 0 together.
        last_press_vec = '0; last_any = 1'b0;
        t0 = cyc + 1;
        run(4'h6, 12);
        chk("simul_vec", 32'(last_press_vec), 32'h9);
        chk("simul_any", 32'(last_any), 32'd1);
        chk("simul_cyc", 32'(press_cyc[3]), 32'(t0 + 5));
        chk("simul_held", 32'(kif.key_held), 32'h9);
        run(4'hF, 12);

        // Reset while key 0 is mid-debounce.
        pc0 = press_cnt[0];
        run(4'hE, 2);
        tick(4'hE, 1'b0);
        tick(4'hE, 1'b0);
        chk("midrst_no_pulse", 32'(press_cnt[0] - pc0), 32'd0);
        t0 = cyc + 1;
        run(4'hE, 10);
        chk("midrst_press_cyc", 32'(press_cyc[0]), 32'(t0 + 5));
        chk("midrst_press_cnt", 32'(press_cnt[0] - pc0), 32'd1);
        run(4'hF, 12);

        // Random key activity with mixed short and long holds, rare resets.
        k = 4'hF;
        for (int n = 0; n < 120; n++) begin
            k[$urandom_range(NK - 1, 0)] ^= 1'b1;
            if ($urandom_range(2, 0) == 0) k[$urandom_range(NK - 1, 0)] ^= 1'b1;
            hold = $urandom_range(8, 1);
            for (int j = 0; j < hold; j++)
                tick(k, ($urandom_range(99, 0) == 0) ? 1'b0 : 1'b1);
        end
        run(4'hF, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions the raw active-low pushbutton inputs (KEY[3:0]) before they reach the filter-select FSM.
- Per key: two-flop synchronisation, counter-based debounce, and registered one-cycle press/release pulses.
- The filter FSM consumes key_press pulses to step filter_type; it never sees bounce or metastable input.
- All keys are independent channels sharing one clock domain.

Parameters:
NUM_KEYS, 4, number of independent key channels
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level (1 ms at 50 MHz); legal range >= 1

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
key  input  NUM_KEYS  raw pushbuttons, asynchronous, active-low (0 = pressed)
key_held  output  NUM_KEYS  debounced level, active-high (1 = pressed)
key_press  output  NUM_KEYS  one-cycle pulse on debounced press
key_release  output  NUM_KEYS  one-cycle pulse on debounced release
key_press_any  output  1  OR of key_press, same cycle

Behaviour:
- Reset: rst_n low asynchronously forces the following state.
  - Sync flops and stable state s[i] to 1 (released).
  - Counters to 0.
  - key_held, key_press, key_release and key_press_any to 0.
- Reset mid-debounce discards the partial count. After rst_n deasserts, a key already held down is accepted as a new press after the full latency. That press does generate a key_press pulse.
- Synchroniser:
  - sync1[i] <= key[i]; sync2[i] <= sync1[i].
  - Only sync2 feeds the debounce logic.
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync2 == s: cnt <= 0.
  - sync2 != s and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != s and cnt == DEBOUNCE_CYCLES-1: s <= sync2 and cnt <= 0.
  - Any single-cycle return of sync2 to s restarts the count from 0. A glitch shorter than DEBOUNCE_CYCLES is therefore never accepted.
- Channel states: STABLE (cnt == 0, sync2 == s) and COUNTING (sync2 != s).
  - STABLE -> COUNTING on mismatch.
  - COUNTING -> STABLE on match, which is a rejected bounce.
  - COUNTING -> STABLE on terminal count, which is an accepted change.
- Outputs (registered, updated on the same edge that updates s):
  - key_held[i] = ~s[i].
  - key_press[i] = 1 for exactly one cycle when s goes 1 -> 0; otherwise 0.
  - key_release[i] = 1 for exactly one cycle when s goes 0 -> 1; otherwise 0.
  - key_press and key_release are never both high on one channel.
- Latency: a raw edge held stable appears on key_held / key_press 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it into sync1.
- DEBOUNCE_CYCLES = 1: the change is accepted on the first mismatch cycle.
- Simultaneous events: channels are fully independent. Several bits of key_press may be high in the same cycle, and key_press_any is then 1.
- Held key:
  - No repeat; key_press fires once per accepted press.
  - key_held stays 1 until release is accepted.
- Counters saturate by construction: they reset on acceptance and cannot wrap.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES = 4. Unless a scenario says otherwise, key = 4'hF at start and rst_n is released at cycle 2.
- Reset: rst_n low with key = 4'h0 -> all outputs 0 during reset. After release, key_press = 4'hF for one cycle exactly 6 edges later, key_press_any = 1, and key_held = 4'hF.
- Clean press: key[0] 1 -> 0 and held -> key_press[0] high exactly 6 edges after the first sampling edge, one cycle wide. key_held[0] = 1 from the same cycle. Releasing after 20 cycles gives key_release[0] one cycle, 6 edges later.
- Bounce rejection: key[1] low 3 cycles, high 1, low 2, high 1, then low steady -> exactly one key_press[1] pulse, 6 edges after the start of the steady-low period. No pulse earlier.
- Glitch: key[2] low for 3 cycles then high -> key_press[2], key_release[2] and key_held[2] stay 0 throughout.
- Simultaneous: key[3] and key[0] pressed on the same edge -> key_press = 4'b1001 in one cycle and key_press_any = 1. One cycle later key_press = 0 and key_held = 4'b1001.
- Reset mid-operation: key[0] pressed and rst_n pulsed low 2 cycles after sampling -> no pulse before reset. After rst_n release, key_press[0] fires 6 edges later.
